clint: RTL

CLINT -- requirements
Module: clint

---
 rtl/clint.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/clint.sv
// Core-local interrupt controller.
// Takes synchronous traps (ecall/ebreak), level-sensitive external interrupts
// and mret. It stalls the pipeline, sequences the mepc, mstatus and mcause CSR
// writes, and then issues a one-cycle PC redirect.
// Optional feature: define CLINT_MPIE_EN to stack MIE into MPIE on trap entry
// and restore it on mret.
module clint (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  int_flag_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_addr_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_flag_i,
  input  logic [31:0] csr_mtvec_i,
  input  logic [31:0] csr_mepc_i,
  input  logic [31:0] csr_mstatus_i,
  input  logic        global_int_en_i,
  output logic        we_o,
  output logic [31:0] waddr_o,
  output logic [31:0] raddr_o,
  output logic [31:0] data_o,
  output logic        hold_flag_o,
  output logic        int_assert_o,
  output logic [31:0] int_addr_o
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] W_MEPC    = 3'd1;
  localparam logic [2:0] W_MSTATUS = 3'd2;
  localparam logic [2:0] W_MCAUSE  = 3'd3;
  localparam logic [2:0] ASSERT    = 3'd4;
  localparam logic [2:0] MRET_W    = 3'd5;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  localparam logic [31:0] CSR_MSTATUS = 32'h0000_0300;
  localparam logic [31:0] CSR_MEPC    = 32'h0000_0341;
  localparam logic [31:0] CSR_MCAUSE  = 32'h0000_0342;

  logic [2:0]  state;
  logic [31:0] cause_q;
  logic [31:0] mepc_q;
  logic        ret_q;     // the pending ASSERT is the end of an mret

  logic        idle_ok;
  logic        sync_req;
  logic        async_req;
  logic        mret_req;
  logic [31:0] sync_cause;
  logic [31:0] async_cause;
  logic [31:0] trap_mstatus;
  logic [31:0] mret_mstatus;

  // Request decode; only evaluated in IDLE and suppressed while reset is held
  always_comb begin
    idle_ok     = (state == IDLE) && !rst;
    sync_req    = idle_ok && ((inst_i == INST_ECALL) || (inst_i == INST_EBREAK));
    async_req   = idle_ok && (int_flag_i != 8'h00) && global_int_en_i && !hold_flag_i;
    mret_req    = idle_ok && (inst_i == INST_MRET);
    sync_cause  = (inst_i == INST_ECALL) ? 32'd11 : 32'd3;
    async_cause = int_flag_i[0] ? 32'h8000_0007 : 32'h8000_000B;
  end

  // mstatus images written on trap entry and on mret
  always_comb begin
    trap_mstatus    = csr_mstatus_i;
    mret_mstatus    = csr_mstatus_i;
`ifdef CLINT_MPIE_EN
    trap_mstatus[7] = csr_mstatus_i[3];
    trap_mstatus[3] = 1'b0;
    mret_mstatus[3] = csr_mstatus_i[7];
    mret_mstatus[7] = 1'b1;
`else
    trap_mstatus[3] = 1'b0;
    mret_mstatus[3] = 1'b1;
`endif
  end

  // Sequencer state and the trap context latched at detection
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cause_q <= '0;
      mepc_q  <= '0;
      ret_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sync_req) begin
            state   <= W_MEPC;
            cause_q <= sync_cause;
            mepc_q  <= inst_addr_i;
            ret_q   <= 1'b0;
          end else if (async_req) begin
            state   <= W_MEPC;
            cause_q <= async_cause;
            mepc_q  <= jump_flag_i ? jump_addr_i : inst_addr_i;
            ret_q   <= 1'b0;
          end else if (mret_req) begin
            state   <= MRET_W;
            ret_q   <= 1'b1;
          end
        end
        W_MEPC:    state <= W_MSTATUS;
        W_MSTATUS: state <= W_MCAUSE;
        W_MCAUSE:  state <= ASSERT;
        MRET_W:    state <= ASSERT;
        ASSERT: begin
          state <= IDLE;
          ret_q <= 1'b0;
        end
        default:   state <= IDLE;
      endcase
    end
  end

  // CSR write port and redirect outputs decoded from the current state
  always_comb begin
    we_o         = 1'b0;
    waddr_o      = '0;
    data_o       = '0;
    int_assert_o = 1'b0;
    int_addr_o   = '0;
    case (state)
      W_MEPC: begin
        we_o    = 1'b1;
        waddr_o = CSR_MEPC;
        data_o  = mepc_q;
      end
      W_MSTATUS: begin
        we_o    = 1'b1;
        waddr_o = CSR_MSTATUS;
        data_o  = trap_mstatus;
      end
      W_MCAUSE: begin
        we_o    = 1'b1;
        waddr_o = CSR_MCAUSE;
        data_o  = cause_q;
      end
      MRET_W: begin
        we_o    = 1'b1;
        waddr_o = CSR_MSTATUS;
        data_o  = mret_mstatus;
      end
      ASSERT: begin
        int_assert_o = 1'b1;
        int_addr_o   = ret_q ? csr_mepc_i : {csr_mtvec_i[31:2], 2'b00};
      end
      default: ;
    endcase
  end

  assign raddr_o     = '0;
  assign hold_flag_o = (state != IDLE) || sync_req || async_req || mret_req;

endmodule
